// File: rtl/digit_pkg.sv
// ----------------------------------------------------------------------------
// digit_pkg
// Shared definitions for the sequential binary-to-decimal display converter:
//   - 7-segment patterns (active-low, bit 0 = segment a ... bit 6 = segment g)
//   - the BCD nibble value used to flag an out-of-range result
//   - the converter state encoding
//   - pow10(), used to compute the overflow limit at elaboration time
// ----------------------------------------------------------------------------
package digit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } conv_state_t;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_ONE   = 7'b1111001;
   localparam logic [6:0] SEG_TWO   = 7'b0100100;
   localparam logic [6:0] SEG_THREE = 7'b0110000;
   localparam logic [6:0] SEG_FOUR  = 7'b0011001;
   localparam logic [6:0] SEG_FIVE  = 7'b0010010;
   localparam logic [6:0] SEG_SIX   = 7'b0000010;
   localparam logic [6:0] SEG_SEVEN = 7'b1111000;
   localparam logic [6:0] SEG_EIGHT = 7'b0000000;
   localparam logic [6:0] SEG_NINE  = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_OVF = 4'hF;

   // 10^n as a 64-bit constant; DIGITS tops out at 8, so this never wraps.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_encoder.sv
// ----------------------------------------------------------------------------
// seg7_encoder
// Combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   nibble   in  4  BCD digit (0-9), or BCD_OVF to request a dash
//   segments out 7  active-low pattern, bit 0 = segment a
// ----------------------------------------------------------------------------
module seg7_encoder
   import digit_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   // Anything outside 0-9 can only be the overflow marker, so it shows a dash.
   always_comb begin
      segments = SEG_DASH;
      case (nibble)
         4'd0:    segments = SEG_ZERO;
         4'd1:    segments = SEG_ONE;
         4'd2:    segments = SEG_TWO;
         4'd3:    segments = SEG_THREE;
         4'd4:    segments = SEG_FOUR;
         4'd5:    segments = SEG_FIVE;
         4'd6:    segments = SEG_SIX;
         4'd7:    segments = SEG_SEVEN;
         4'd8:    segments = SEG_EIGHT;
         4'd9:    segments = SEG_NINE;
         default: segments = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seq_digit_converter.sv
// ----------------------------------------------------------------------------
// seq_digit_converter
// Iterative (double-dabble, one bit per clock) binary to packed-BCD converter
// with 7-segment outputs and explicit overflow indication.
// Parameters:
//   BIN_W   width of the unsigned binary input (1..32)
//   DIGITS  number of decimal digits produced (1..8)
// Ports:
//   CLK       in   1          system clock, rising edge
//   RESET     in   1          asynchronous active-high reset
//   START     in   1          single-cycle request, BIN_IN captured same edge
//   BIN_IN    in   BIN_W      value to convert
//   BUSY      out  1          conversion in progress
//   DONE      out  1          one-cycle pulse when results update
//   OVERFLOW  out  1          last value was >= 10^DIGITS
//   BCD_OUT   out  4*DIGITS   packed BCD, units in [3:0]
//   SEGMENTS  out  7*DIGITS   active-low patterns, units in [6:0]
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank zero digits above the most significant
//                          nonzero digit (units digit always shown)
// ----------------------------------------------------------------------------
module seq_digit_converter
   import digit_pkg::*;
#(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
)
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [BIN_W-1:0]      BIN_IN,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  OVERFLOW,
   output logic [4*DIGITS-1:0]   BCD_OUT,
   output logic [7*DIGITS-1:0]   SEGMENTS
);

   localparam int          ACC_W = 4 * DIGITS;
   localparam int          CNT_W = $clog2(BIN_W + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS);

   conv_state_t        state, next_state;
   logic [BIN_W-1:0]   shift_reg;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   bcd_reg;
   logic [CNT_W-1:0]   bit_cnt;
   logic               ovf_pending;
   logic               ovf_reg;
   logic               done_reg;
   logic               load;
   logic               step;
   logic               finish;
   logic [DIGITS-1:0]  blank_mask;
   logic [7*DIGITS-1:0] enc_seg;

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and datapath control. START outside IDLE is simply not
   // looked at, which is what keeps an in-flight conversion undisturbed.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (bit_cnt == CNT_W'(1)) begin
               next_state = FINISH;
            end
         end
         FINISH: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Double-dabble correction: any nibble >= 5 gets +3 so the following
   // left shift carries correctly into the next decimal digit.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // Datapath. Overflow is decided from the captured value up front, so the
   // accumulator's top-nibble carry-out can be thrown away by the shift, and
   // the iteration always runs the full BIN_W steps regardless of data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         shift_reg   <= '0;
         acc         <= '0;
         bit_cnt     <= '0;
         ovf_pending <= 1'b0;
         bcd_reg     <= '0;
         ovf_reg     <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (load) begin
            shift_reg   <= BIN_IN;
            acc         <= '0;
            bit_cnt     <= CNT_W'(BIN_W);
            ovf_pending <= (64'(BIN_IN) >= LIMIT);
         end
         if (step) begin
            acc       <= (acc_adj << 1) | ACC_W'(shift_reg[BIN_W-1]);
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - CNT_W'(1);
         end
         if (finish) begin
            bcd_reg  <= ovf_pending ? {DIGITS{BCD_OVF}} : acc;
            ovf_reg  <= ovf_pending;
            done_reg <= 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic leading;

   // Walk from the top digit down; zeros are blanked until the first nonzero
   // digit. Digit 0 is outside the loop so it is always displayed.
   always_comb begin
      blank_mask = '0;
      leading    = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (leading && (bcd_reg[4*i +: 4] == 4'd0)) begin
            blank_mask[i] = 1'b1;
         end else begin
            leading = 1'b0;
         end
      end
   end
`else
   assign blank_mask = '0;
`endif

   // One encoder per digit, driven from the registered result so the display
   // holds the last conversion between runs.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      seg7_encoder u_enc (
         .nibble   (bcd_reg[4*g +: 4]),
         .segments (enc_seg[7*g +: 7])
      );
      assign SEGMENTS[7*g +: 7] = blank_mask[g] ? SEG_BLANK : enc_seg[7*g +: 7];
   end

   assign BUSY     = (state != IDLE);
   assign DONE     = done_reg;
   assign OVERFLOW = ovf_reg;
   assign BCD_OUT  = bcd_reg;

endmodule

// File: tb/tb_seq_digit_converter.sv
// ----------------------------------------------------------------------------
// tb_seq_digit_converter
// Scoreboard bench for seq_digit_converter: a 7-bit/2-digit instance driven
// with directed vectors, and a 10-bit/3-digit instance swept over every input.
// Expected results are queued at START; monitors pop and compare on DONE.
// Honours LEADING_ZERO_BLANK_EN for the expected display patterns.
// ----------------------------------------------------------------------------
module tb_seq_digit_converter;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = SB;
`else
   localparam logic [6:0] LZ = S0;
`endif

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
      logic [55:0] seg;
      int          cyc;
   } exp_t;

   logic        CLK;
   logic        RESET;
   logic        start1, start3;
   logic [6:0]  bin1;
   logic [9:0]  bin3;
   logic        busy1, done1, ovf1;
   logic [7:0]  bcd1;
   logic [13:0] seg1;
   logic        busy3, done3, ovf3;
   logic [11:0] bcd3;
   logic [20:0] seg3;

   int   tests = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;

   seq_digit_converter #(.BIN_W(7), .DIGITS(2)) dut (
      .CLK(CLK), .RESET(RESET), .START(start1), .BIN_IN(bin1),
      .BUSY(busy1), .DONE(done1), .OVERFLOW(ovf1),
      .BCD_OUT(bcd1), .SEGMENTS(seg1)
   );

   seq_digit_converter #(.BIN_W(10), .DIGITS(3)) dut3 (
      .CLK(CLK), .RESET(RESET), .START(start3), .BIN_IN(bin3),
      .BUSY(busy3), .DONE(done3), .OVERFLOW(ovf3),
      .BCD_OUT(bcd3), .SEGMENTS(seg3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0: return S0;
         4'd1: return S1;
         4'd2: return S2;
         4'd3: return S3;
         4'd4: return S4;
         4'd5: return S5;
         4'd6: return S6;
         4'd7: return S7;
         4'd8: return S8;
         4'd9: return S9;
         default: return SD;
      endcase
   endfunction

   function automatic logic [55:0] expSeg(input logic [31:0] bcd, input int ndig);
      logic [55:0] s;
      logic [3:0]  d;
`ifdef LEADING_ZERO_BLANK_EN
      logic        lead;
      lead = 1'b1;
`endif
      s = '0;
      for (int i = ndig - 1; i >= 0; i--) begin
         d = bcd[4*i +: 4];
         s[7*i +: 7] = segOf(d);
`ifdef LEADING_ZERO_BLANK_EN
         if (i != 0 && lead && d == 4'd0) s[7*i +: 7] = SB;
         else lead = 1'b0;
`endif
      end
      return s;
   endfunction

   // Issue one START pulse; returns the cycle number of the capturing edge.
   task automatic pulseStart(input int which, input logic [31:0] value, output int c);
      if (which == 1) begin
         bin1 = value[6:0];
         start1 = 1'b1;
      end else begin
         bin3 = value[9:0];
         start3 = 1'b1;
      end
      @(posedge CLK);
      #1;
      c = cyc;
      start1 = 1'b0;
      start3 = 1'b0;
      @(negedge CLK);
   endtask

   task automatic applyStimulus(input int which, input logic [31:0] value,
                                input logic [31:0] exp_bcd, input logic exp_ovf,
                                input logic [55:0] exp_seg);
      int   c;
      exp_t e;
      pulseStart(which, value, c);
      e.bcd = exp_bcd;
      e.ovf = exp_ovf;
      e.seg = exp_seg;
      if (which == 1) begin
         e.cyc = c + 8;
         q1.push_back(e);
      end else begin
         e.cyc = c + 11;
         q3.push_back(e);
      end
   endtask

   task automatic waitDone(input int which);
      int n;
      n = 0;
      @(negedge CLK);
      while (((which == 1) ? done1 : done3) == 1'b0 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      if (((which == 1) ? done1 : done3) == 1'b0) checkOutput("done_timeout", 0, 1);
   endtask

   // Monitors: every DONE must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (done1) begin
         if (q1.size() == 0) begin
            checkOutput("unexpected_done1", 1, 0);
         end else begin
            e1 = q1.pop_front();
            checkOutput("bcd1", 64'(bcd1), 64'(e1.bcd));
            checkOutput("ovf1", 64'(ovf1), 64'(e1.ovf));
            checkOutput("seg1", 64'(seg1), 64'(e1.seg));
            checkOutput("latency1", 64'(cyc), 64'(e1.cyc));
            checkOutput("busy_at_done1", 64'(busy1), 0);
         end
      end
   end

   always @(negedge CLK) begin
      if (done3) begin
         if (q3.size() == 0) begin
            checkOutput("unexpected_done3", 1, 0);
         end else begin
            e3 = q3.pop_front();
            checkOutput("bcd3", 64'(bcd3), 64'(e3.bcd));
            checkOutput("ovf3", 64'(ovf3), 64'(e3.ovf));
            checkOutput("seg3", 64'(seg3), 64'(e3.seg));
            checkOutput("latency3", 64'(cyc), 64'(e3.cyc));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int c;
      logic [31:0] eb;
      RESET = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      bin1 = '0;
      bin3 = '0;
      repeat (2) @(negedge CLK);

      checkOutput("reset_busy", 64'(busy1), 0);
      checkOutput("reset_done", 64'(done1), 0);
      checkOutput("reset_ovf", 64'(ovf1), 0);
      checkOutput("reset_bcd", 64'(bcd1), 0);
      checkOutput("reset_seg", 64'(seg1), 64'({LZ, S0}));
      checkOutput("reset_bcd3", 64'(bcd3), 0);
      RESET = 1'b0;
      @(negedge CLK);

      // 42 -> "42"
      applyStimulus(1, 42, 32'h42, 1'b0, 56'({S4, S2}));
      checkOutput("busy_high", 64'(busy1), 1);
      waitDone(1);
      repeat (2) @(negedge CLK);

      // 99 then 100 back to back; 100 is the first overflowing value
      applyStimulus(1, 99, 32'h99, 1'b0, 56'({S9, S9}));
      waitDone(1);
      applyStimulus(1, 100, 32'hFF, 1'b1, 56'({SD, SD}));
      waitDone(1);

      // Leading-zero display cases
      applyStimulus(1, 7, 32'h07, 1'b0, 56'({LZ, S7}));
      waitDone(1);
      applyStimulus(1, 0, 32'h00, 1'b0, 56'({LZ, S0}));
      waitDone(1);
      applyStimulus(1, 127, 32'hFF, 1'b1, 56'({SD, SD}));
      waitDone(1);

      // START during a conversion is ignored
      applyStimulus(1, 55, 32'h55, 1'b0, 56'({S5, S5}));
      repeat (2) @(negedge CLK);
      pulseStart(1, 12, c);
      waitDone(1);
      repeat (12) @(negedge CLK);
      checkOutput("held_bcd", 64'(bcd1), 64'h55);
      checkOutput("held_busy", 64'(busy1), 0);

      // Reset mid-conversion aborts without DONE
      pulseStart(1, 63, c);
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      #1;
      checkOutput("abort_busy", 64'(busy1), 0);
      checkOutput("abort_bcd", 64'(bcd1), 0);
      checkOutput("abort_seg", 64'(seg1), 64'({LZ, S0}));
      @(negedge CLK);
      RESET = 1'b0;
      repeat (12) @(negedge CLK);
      checkOutput("after_abort_bcd", 64'(bcd1), 0);
      applyStimulus(1, 63, 32'h63, 1'b0, 56'({S6, S3}));
      waitDone(1);

      // Full sweep of the 10-bit, 3-digit instance
      for (int v = 0; v < 1024; v++) begin
         if (v >= 1000) eb = 32'hFFF;
         else eb = {20'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         applyStimulus(3, 32'(v), eb, (v >= 1000), expSeg(eb, 3));
         waitDone(3);
      end

      repeat (5) @(negedge CLK);
      checkOutput("pending_q1", 64'(q1.size()), 0);
      checkOutput("pending_q3", 64'(q3.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/seq_digit_converter.md
Name: seq_digit_converter

Overview:
- Parametrised sequential binary-to-decimal display converter; successor to the fixed 7-bit, two-digit distance converter.
- Accepts a BIN_W-bit unsigned value on a START strobe and runs iterative shift-add-3 (double-dabble), one bit per clock.
- Produces DIGITS packed BCD nibbles plus matching 7-segment patterns for the HEX displays, with explicit overflow indication instead of undriven outputs.
- Sits between the distance measurement logic and the display/alarm logic.

Parameters:
- BIN_W, 7, width of the unsigned binary input; legal range 1..32.
- DIGITS, 2, number of decimal digits produced; legal range 1..8.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  single-cycle request; BIN_IN is captured on the same edge.
- BIN_IN  input  BIN_W  unsigned value to convert.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when results update.
- OVERFLOW  output  1  registered; BIN_IN was at least 10^DIGITS.
- BCD_OUT  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0].
- SEGMENTS  output  7*DIGITS  7-segment patterns, digit 0 in [6:0]. Active-low. Bit 0 is segment a through bit 6 is segment g.

Behaviour:
- Reset values, asserted asynchronously: state IDLE, BUSY=0, DONE=0, OVERFLOW=0, BCD_OUT=0, every SEGMENTS digit showing "0" (7'b1000000).
- States:
  - IDLE: if START=1, capture BIN_IN into the shift register, clear the BCD accumulator, load bit counter with BIN_W, go to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator nibble greater than or equal to 5, then shift left one bit, taking the MSB of the shift register. Decrement the counter; at counter==1, go to FINISH.
  - FINISH: register the results, pulse DONE for one cycle, return to IDLE.
- Latency: START sampled at edge N; DONE=1 and new BCD_OUT/SEGMENTS/OVERFLOW visible after edge N+BIN_W+1.
- Back-to-back: START is accepted in the cycle after DONE, so throughput is one conversion per BIN_W+2 cycles.
- BUSY=1 from the edge after START is accepted through the FINISH cycle inclusive; BUSY=0 while DONE is high.
- START while BUSY=1 is ignored entirely; no queuing, and the in-flight value is undisturbed.
- Outputs hold the last result between conversions.
- Overflow:
  - Compare the captured value against the constant LIMIT=10^DIGITS, computed at elaboration.
  - If value is at least LIMIT: OVERFLOW=1, every BCD nibble = 4'hF, every digit shows dash (7'b0111111).
  - If 10^DIGITS exceeds 2^BIN_W, overflow is unreachable.
  - The iteration still runs its full BIN_W cycles, so latency is data-independent.
- The accumulator is DIGITS*4 bits; the top nibble's carry-out is discarded, which is safe because overflow is pre-detected.
- RESET mid-conversion: abort immediately, return all outputs to reset values, no DONE pulse.
- Encoding for digits 0-9: standard DE-board active-low patterns. Nibble values 10-15 never reach the encoder except 4'hF on overflow, which maps to dash.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: after each conversion, zero digits above the most significant nonzero digit are blanked (7'b1111111). Digit 0 is never blanked, so value 0 shows a single "0". Reset shows only digit 0 as "0" with higher digits blank. BCD_OUT is unaffected.
- When undefined: all digits are always displayed, including leading zeros.

Decomposition:
- Shared package digit_pkg holds:
  - SEG_ZERO..SEG_NINE, SEG_DASH, SEG_BLANK constants (7-bit, active-low).
  - BCD_OVF nibble constant (4'hF).
  - State encoding constants IDLE/SHIFT/FINISH.
- One combinational sub-module, seg7_encoder (4-bit nibble in, 7-bit active-low pattern out), instantiated DIGITS times via generate.

Test Plan:
- BIN_IN=42, START pulse (BIN_W=7, DIGITS=2) -> after 8 edges DONE=1; BCD_OUT=8'h42; SEGMENTS[13:7]=7'b0011001, [6:0]=7'b0100100; OVERFLOW=0.
- BIN_IN=99 then BIN_IN=100 back-to-back -> first gives 8'h99; second gives OVERFLOW=1, BCD_OUT=8'hFF, both digits 7'b0111111; each DONE at 8 edges after its START.
- BIN_IN=7:
  - With LEADING_ZERO_BLANK_EN: SEGMENTS[13:7]=7'b1111111, [6:0]=7'b1111000.
  - Without it: [13:7]=7'b1000000.
  - BIN_IN=0 shows units "0" in both builds.
- START with BIN_IN=55, then START with BIN_IN=12 at cycle 3 -> second START ignored; result 8'h55; exactly one DONE pulse.
- Assert RESET for 1 cycle at cycle 4 of a conversion of 63 -> BUSY=0 and BCD_OUT=0 asynchronously; no DONE; a fresh START with 63 then yields 8'h63.
- Sweep BIN_W=10, DIGITS=3 over all 1024 values -> BCD_OUT matches reference decimal for values 0-999; OVERFLOW=1 exactly for values 1000-1023.
